// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO controller: op encodings, FSM states and
// the multiplier/divider latency.
package hilo_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned MD_LATENCY = 34;

    localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] OP_MFHI  = 4'd5;
    localparam logic [OP_W-1:0] OP_MFLO  = 4'd6;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd7;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_e;

    // Ops that launch a mul_div operation.
    function automatic logic is_md_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Ops that touch HI/LO and therefore must wait for an in-flight operation.
    function automatic logic is_hilo_op(input logic [OP_W-1:0] op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// Decode-side request bus and mul_div control bus of the HI/LO controller.
interface hilo_unit_if;
    import hilo_pkg::*;

    logic                valid_i;
    logic [OP_W-1:0]     op_i;
    logic [XLEN-1:0]     rs_i;
    logic [XLEN-1:0]     rt_i;
    logic                flush_i;
    logic [2*XLEN-1:0]   md_result_i;
    logic                md_ready_i;
    logic                md_start_o;
    logic                md_sel_mul_o;
    logic                md_signed_o;
    logic [XLEN-1:0]     md_op1_o;
    logic [XLEN-1:0]     md_op2_o;
    logic                md_annul_o;
    logic                stall_o;
    logic [XLEN-1:0]     rd_data_o;
    logic [XLEN-1:0]     hi_o;
    logic [XLEN-1:0]     lo_o;
    logic                md_err_o;

    modport slave (
        input  valid_i, op_i, rs_i, rt_i, flush_i, md_result_i, md_ready_i,
        output md_start_o, md_sel_mul_o, md_signed_o, md_op1_o, md_op2_o, md_annul_o,
        output stall_o, rd_data_o, hi_o, lo_o, md_err_o
    );

    modport master (
        output valid_i, op_i, rs_i, rt_i, flush_i, md_result_i, md_ready_i,
        input  md_start_o, md_sel_mul_o, md_signed_o, md_op1_o, md_op2_o, md_annul_o,
        input  stall_o, rd_data_o, hi_o, lo_o, md_err_o
    );

endinterface

// File: rtl/hilo_unit.sv
// Execute-stage HI/LO owner: issues MULT/DIV to mul_div, holds operands until
// the result returns, commits HI/LO, and swallows results killed by a flush.
module hilo_unit #(
    parameter int unsigned MD_LATENCY = hilo_pkg::MD_LATENCY,
    parameter int unsigned WD_LIMIT   = 40
) (
    input  logic        clk,
    input  logic        rst,
    hilo_unit_if.slave  bus
);
    import hilo_pkg::*;

    localparam int unsigned    WD_W       = 6;
    localparam logic [WD_W-1:0] WD_LIMIT_C = WD_W'(WD_LIMIT);

    // The watchdog must never fire on a healthy operation.
    if ((WD_LIMIT <= MD_LATENCY) || (WD_LIMIT >= (1 << WD_W))) begin : g_bad_wd_limit
        $error("hilo_unit: WD_LIMIT must exceed MD_LATENCY and fit the watchdog counter");
    end

    state_e            state_q, state_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   op1_q, op1_d;
    logic [XLEN-1:0]   op2_q, op2_d;
    logic              sel_mul_q, sel_mul_d;
    logic              signed_q, signed_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic              accept_c;
    logic              issue_c;
    logic [WD_W-1:0]   wd_inc_c;

    assign accept_c = bus.valid_i && !bus.flush_i;
    assign issue_c  = accept_c && (state_q == IDLE) && is_md_op(bus.op_i);
    assign wd_inc_c = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + WD_W'(1);

    // Next-state, HI/LO update and operand capture.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        sel_mul_d = sel_mul_q;
        signed_d  = signed_q;
        wd_cnt_d  = wd_cnt_q;

        case (state_q)
            IDLE: begin
                if (issue_c) begin
                    state_d   = BUSY;
                    op1_d     = bus.rs_i;
                    op2_d     = bus.rt_i;
                    sel_mul_d = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU);
                    signed_d  = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
                    wd_cnt_d  = '0;
                end else if (accept_c && (bus.op_i == OP_MTHI)) begin
                    hi_d = bus.rs_i;
                end else if (accept_c && (bus.op_i == OP_MTLO)) begin
                    lo_d = bus.rs_i;
                end
            end
            BUSY: begin
                wd_cnt_d = wd_inc_c;
                // A flush coinciding with ready still discards the result.
                if (bus.flush_i) begin
                    state_d = bus.md_ready_i ? IDLE : ABORT;
                end else if (bus.md_ready_i) begin
                    hi_d    = bus.md_result_i[2*XLEN-1:XLEN];
                    lo_d    = bus.md_result_i[XLEN-1:0];
                    state_d = IDLE;
                end
            end
            ABORT: begin
                wd_cnt_d = wd_inc_c;
                if (bus.md_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_d = err_q || ((state_q != IDLE) && (wd_cnt_d >= WD_LIMIT_C));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            sel_mul_q <= 1'b0;
            signed_q  <= 1'b0;
            err_q     <= 1'b0;
            wd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            sel_mul_q <= sel_mul_d;
            signed_q  <= signed_d;
            err_q     <= err_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

    // Start drops in the ready cycle so mul_div does not relaunch on stale state.
    assign bus.md_start_o   = (state_q != IDLE) && !bus.md_ready_i;
    assign bus.md_sel_mul_o = sel_mul_q;
    assign bus.md_signed_o  = signed_q;
    assign bus.md_op1_o     = op1_q;
    assign bus.md_op2_o     = op2_q;
    assign bus.md_annul_o   = 1'b0;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;
    assign bus.md_err_o     = err_q;
    assign bus.stall_o      = accept_c && is_hilo_op(bus.op_i) && (state_q != IDLE);

    always_comb begin
        bus.rd_data_o = '0;
        if ((state_q == IDLE) && bus.valid_i) begin
            if (bus.op_i == OP_MFHI) begin
                bus.rd_data_o = hi_q;
            end else if (bus.op_i == OP_MFLO) begin
                bus.rd_data_o = lo_q;
            end
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized and directed bench for hilo_unit with a behavioural mul_div and
// an architectural HI/LO reference model.
`timescale 1ns/1ps
module tb_hilo_unit;
    import hilo_pkg::*;

    localparam int unsigned LAT = 34;
    localparam int unsigned WDL = 40;

    logic clk = 1'b0;
    logic rst;
    hilo_unit_if bus();

    hilo_unit #(.MD_LATENCY(LAT), .WD_LIMIT(WDL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_hi, exp_lo;
    bit          md_hang;
    bit          md_run;
    int          md_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Arithmetic meaning of each op: product, or {remainder, quotient}.
    function automatic logic [63:0] md_ref(input logic mul, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (mul) begin
            if (sgn) return 64'(sa * sb);
            return {32'b0, a} * {32'b0, b};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Behavioural mul_div: counts LAT start-high edges, then pulses ready.
    always @(posedge clk) begin
        if (rst) begin
            md_run = 1'b0;
            md_cnt = 0;
            bus.md_ready_i <= 1'b0;
        end else begin
            bus.md_ready_i <= 1'b0;
            if (md_run) begin
                md_cnt = md_cnt + 1;
                if (md_cnt >= int'(LAT) && !md_hang) begin
                    md_run = 1'b0;
                    bus.md_ready_i  <= 1'b1;
                    bus.md_result_i <= md_ref(bus.md_sel_mul_o, bus.md_signed_o,
                                              bus.md_op1_o, bus.md_op2_o);
                end
            end else if (bus.md_start_o) begin
                md_run = 1'b1;
                md_cnt = 1;
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fl);
        bus.valid_i = v;
        bus.op_i    = op;
        bus.rs_i    = a;
        bus.rt_i    = b;
        bus.flush_i = fl;
    endtask

    task automatic idle();
        drive(1'b0, OP_NOP, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hi"},     64'(bus.hi_o), 64'd0);
        check({tag, "_lo"},     64'(bus.lo_o), 64'd0);
        check({tag, "_start"},  64'(bus.md_start_o), 64'd0);
        check({tag, "_op1"},    64'(bus.md_op1_o), 64'd0);
        check({tag, "_op2"},    64'(bus.md_op2_o), 64'd0);
        check({tag, "_sel"},    64'(bus.md_sel_mul_o), 64'd0);
        check({tag, "_sgn"},    64'(bus.md_signed_o), 64'd0);
        check({tag, "_err"},    64'(bus.md_err_o), 64'd0);
        check({tag, "_annul"},  64'(bus.md_annul_o), 64'd0);
        // A HI/LO op in front of an idle unit must not stall.
        drive(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        #1;
        check({tag, "_stall"},  64'(bus.stall_o), 64'd0);
        check({tag, "_rd"},     64'(bus.rd_data_o), 64'd0);
        idle();
    endtask

    // Issue one mul/div from IDLE, optionally flush at busy cycle flush_at, and
    // hold a follow-up instruction (nop) in EX while the operation is in flight.
    // Returns at the first negedge with the unit back in IDLE.
    task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input logic [3:0] nop,
                         input logic [31:0] na, input logic [31:0] nb);
        logic mul, sgn, hilo_next;
        logic [63:0] res;
        int n;
        bit seen;
        mul = (op == OP_MULT) || (op == OP_MULTU);
        sgn = (op == OP_MULT) || (op == OP_DIV);
        res = md_ref(mul, sgn, a, b);
        hilo_next = (nop >= OP_MULT) && (nop <= OP_MTLO);

        drive(1'b1, op, a, b, 1'b0);
        #1;
        check("issue_stall", 64'(bus.stall_o), 64'd0);
        check("issue_start", 64'(bus.md_start_o), 64'd0);
        @(negedge clk);
        drive(nop != OP_NOP, nop, na, nb, 1'b0);

        n = 0;
        seen = 1'b0;
        while (!seen && n <= int'(LAT) + 5) begin
            if (n == flush_at) bus.flush_i = 1'b1;
            #1;
            check("op1_hold", 64'(bus.md_op1_o), 64'(a));
            check("op2_hold", 64'(bus.md_op2_o), 64'(b));
            check("sel_hold", 64'(bus.md_sel_mul_o), 64'(mul));
            check("sgn_hold", 64'(bus.md_signed_o), 64'(sgn));
            check("start_busy", 64'(bus.md_start_o), 64'(n != int'(LAT)));
            if (nop != OP_NOP)
                check("stall_busy", 64'(bus.stall_o), 64'(hilo_next && (n != flush_at)));
            if (nop == OP_MFHI || nop == OP_MFLO)
                check("rd_busy", 64'(bus.rd_data_o), 64'd0);
            if (bus.md_ready_i) begin
                seen = 1'b1;
                check("ready_cycle", 64'(n), 64'(LAT));
            end
            @(negedge clk);
            bus.flush_i = 1'b0;
            n++;
        end
        if (!seen) check("ready_timeout", 64'd0, 64'd1);

        if (flush_at < 0 || flush_at > int'(LAT)) begin
            exp_hi = res[63:32];
            exp_lo = res[31:0];
        end
        #1;
        check("commit_hi", 64'(bus.hi_o), 64'(exp_hi));
        check("commit_lo", 64'(bus.lo_o), 64'(exp_lo));
        check("idle_start", 64'(bus.md_start_o), 64'd0);
        if (nop != OP_NOP) check("stall_idle", 64'(bus.stall_o), 64'd0);
        if (nop == OP_MFHI) check("rd_hi", 64'(bus.rd_data_o), 64'(exp_hi));
        if (nop == OP_MFLO) check("rd_lo", 64'(bus.rd_data_o), 64'(exp_lo));
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] d, input logic fl);
        drive(1'b1, op, d, 32'd0, fl);
        #1;
        check("mt_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        idle();
        if (!fl) begin
            if (op == OP_MTHI) exp_hi = d;
            else exp_lo = d;
        end
        #1;
        check("mt_hi", 64'(bus.hi_o), 64'(exp_hi));
        check("mt_lo", 64'(bus.lo_o), 64'(exp_lo));
        @(negedge clk);
    endtask

    task automatic mf(input logic [3:0] op);
        drive(1'b1, op, 32'd0, 32'd0, 1'b0);
        #1;
        check("mf_stall", 64'(bus.stall_o), 64'd0);
        check("mf_rd", 64'(bus.rd_data_o), 64'(op == OP_MFHI ? exp_hi : exp_lo));
        @(negedge clk);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  rop, rnop;
        logic [31:0] ra, rb;
        int          rfl;

        idle();
        md_hang = 1'b0;
        rst = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // MULT -3 * 7
        do_md(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, OP_NOP, 32'd0, 32'd0);
        check("mult_hi_const", 64'(bus.hi_o), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(bus.lo_o), 64'hFFFF_FFEB);

        // DIVU 100 / 7 with a dependent MFLO stalled behind it
        do_md(OP_DIVU, 32'd100, 32'd7, -1, OP_MFLO, 32'd0, 32'd0);
        check("divu_mflo_const", 64'(bus.rd_data_o), 64'd14);
        check("divu_hi_const", 64'(bus.hi_o), 64'd2);
        idle();

        // DIV -100 / 7
        do_md(OP_DIV, 32'hFFFF_FF9C, 32'd7, -1, OP_NOP, 32'd0, 32'd0);
        check("div_lo_const", 64'(bus.lo_o), 64'hFFFF_FFF2);
        check("div_hi_const", 64'(bus.hi_o), 64'hFFFF_FFFE);

        // Flush at cycle 10 of MULTU 5x6, with a MULT waiting behind it
        mt(OP_MTHI, 32'hA5A5_A5A5, 1'b0);
        do_md(OP_MULTU, 32'd5, 32'd6, 10, OP_MULT, 32'd3, 32'd4);
        check("flush_hi_kept", 64'(bus.hi_o), 64'hA5A5_A5A5);
        idle();

        // Flush in the same cycle as ready: result is still dropped
        do_md(OP_MULT, 32'd9, 32'd9, int'(LAT), OP_MFHI, 32'd0, 32'd0);
        check("flush_ready_hi", 64'(bus.hi_o), 64'hA5A5_A5A5);
        idle();

        // Back-to-back MULTU, and a non-HI/LO op that must never stall
        do_md(OP_MULTU, 32'd2, 32'd3, -1, OP_MULTU, 32'd4, 32'd5);
        check("b2b_first_lo", 64'(bus.lo_o), 64'd6);
        do_md(OP_MULTU, 32'd4, 32'd5, -1, 4'd12, 32'd0, 32'd0);
        check("b2b_final_lo", 64'(bus.lo_o), 64'd20);
        check("b2b_final_hi", 64'(bus.hi_o), 64'd0);
        idle();

        // NOP reads as zero; flushed MTLO does not write
        drive(1'b1, OP_NOP, 32'h1234, 32'd0, 1'b0);
        #1;
        check("nop_rd", 64'(bus.rd_data_o), 64'd0);
        @(negedge clk);
        mt(OP_MTLO, 32'hDEAD_BEEF, 1'b1);

        // Randomized mix
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    rop  = 4'($urandom_range(1, 4));
                    ra   = $urandom;
                    rb   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                    if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
                    rfl  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, LAT)) : -1;
                    rnop = 4'($urandom_range(0, 2));
                    if (rnop != OP_NOP) rnop = rnop + 4'd4;
                    do_md(rop, ra, rb, rfl, rnop, 32'd0, 32'd0);
                    idle();
                end
                3: mt(($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, $urandom, 1'b0);
                4: mf(($urandom_range(0, 1) == 0) ? OP_MFHI : OP_MFLO);
                default: mt(OP_MTHI, $urandom, 1'b1);
            endcase
        end

        // Reset in the middle of an operation
        drive(1'b1, OP_MULT, 32'd11, 32'd13, 1'b0);
        @(negedge clk);
        idle();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        #1;
        check_reset_vals("rst_busy");
        @(negedge clk);

        // Watchdog with mul_div never answering
        md_hang = 1'b1;
        drive(1'b1, OP_MULT, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        idle();
        for (int n = 0; n <= int'(WDL) + 3; n++) begin
            #1;
            check("wd_err", 64'(bus.md_err_o), 64'(n >= int'(WDL)));
            @(negedge clk);
        end
        rst = 1'b1;
        md_hang = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("wd_rst");
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Execute-stage controller that owns the HI/LO register pair and sequences the 34-cycle iterative multiplier/divider (`mul_div`). It accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from decode. It drives and holds the multiplier/divider operands and controls, stalls HI/LO-dependent instructions while an operation is in flight, and commits the 64-bit result into HI/LO. It also absorbs flushes, because `mul_div` cannot be aborted mid-operation.

## Interface
Parameters:
- `MD_LATENCY`, default 34: clock edges from the first edge with `md_start_o` high until `md_ready_i` is high. Used by the watchdog only.
- `WD_LIMIT`, default 40: busy-cycle count at which `md_err_o` sets.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `valid_i`  in  1  instruction in EX is valid
- `op_i`  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others NOP
- `rs_i`  in  32  rs operand (dividend / multiplicand / MTxx data)
- `rt_i`  in  32  rt operand (divisor / multiplier)
- `flush_i`  in  1  kill the EX instruction and any in-flight mul/div result
- `md_result_i`  in  64  `mul_div` result. Mul gives the product. Div gives {remainder, quotient}.
- `md_ready_i`  in  1  `mul_div` ready
- `md_start_o`  out  1  to `mul_div` `start_i`
- `md_sel_mul_o`  out  1  1 = multiply, 0 = divide
- `md_signed_o`  out  1  signed operation
- `md_op1_o`, `md_op2_o`  out  32  operands
- `md_annul_o`  out  1  tied 0 (`mul_div` ignores it)
- `stall_o`  out  1  hold the pipeline at EX
- `rd_data_o`  out  32  MFHI/MFLO read data
- `hi_o`, `lo_o`  out  32  architectural HI/LO
- `md_err_o`  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, BUSY, ABORT.
- **IDLE, issue:** on `valid_i` && `op_i` in 1..4 && !`flush_i`:
  - latch `rs_i`/`rt_i` into `md_op1_o`/`md_op2_o`.
  - latch `sel_mul` = (op is 1 or 2) and `signed` = (op is 1 or 3).
  - go to BUSY.
  - Controls and operands stay constant until the state returns to IDLE. `mul_div` samples `sel`/`signed` every cycle.
- **Start signal:** `md_start_o` = (state is BUSY or ABORT) && !`md_ready_i`.
  - This is combinational on `md_ready_i`. Start must be low at the edge after ready rises; otherwise `mul_div` restarts with a stale count.
- **BUSY:**
  - on `md_ready_i`: HI <= `md_result_i[63:32]`, LO <= `md_result_i[31:0]`; go to IDLE.
  - on `flush_i` (and not ready): go to ABORT.
  - on `flush_i` && `md_ready_i`: the flush wins. Go to IDLE with HI/LO unchanged.
- **ABORT:** keep start high until `md_ready_i`, discard the result, go to IDLE. HI/LO are unchanged.
- **MTHI/MTLO in IDLE** (valid, not flushed): HI (MTHI) or LO (MTLO) <= `rs_i` at the edge.
- **MFHI/MFLO in IDLE:** `rd_data_o` = HI or LO combinationally. `rd_data_o` = 0 otherwise.
- **Stall:** `stall_o` = `valid_i` && !`flush_i` && `op_i` in 1..8 && state != IDLE. Non-HI/LO instructions never stall.
- **Divide by zero:** completes normally. HI/LO take whatever `mul_div` returns. No trap.
- **Watchdog:**
  - a 6-bit counter clears on entry to BUSY and increments each BUSY/ABORT cycle.
  - reaching `WD_LIMIT` sets `md_err_o`, which stays set until `rst`.

## Timing
- **Reset values:** state IDLE; HI = LO = 0; `md_start_o` = 0; `md_op1_o` = `md_op2_o` = 0; `md_sel_mul_o` = `md_signed_o` = 0; `stall_o` = 0; `md_err_o` = 0; counter = 0.
- **Reset mid-operation:** abandons the operation. `mul_div` is reset by the same `rst`.
- **Issue and completion:**
  - issue at edge E0; `md_start_o` high from E0.
  - `md_ready_i` high after E0+34; start low in that same cycle.
  - HI/LO written at E0+35; state IDLE at E0+35.
- **Back-to-back:**
  - a mul/div presented while BUSY stalls. It issues at the edge where state returns to IDLE: IDLE is seen in the cycle after E0+35, so it issues at E0+36.
  - minimum start-low gap: 1 cycle.
- MTHI/MTLO: single-cycle, no stall in IDLE.

## Structure
- Shared package `hilo_pkg`:
  - op encodings `OP_NOP`…`OP_MTLO`
  - state enum IDLE/BUSY/ABORT
  - `MD_LATENCY`
- No sub-module; `mul_div` is instantiated by the parent EX stage, alongside this block.

## Test plan
- **MULT:** rs = −3 (0xFFFFFFFD), rt = 7.
  - start high 34 cycles, ready seen.
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFEB at E0+35.
  - start low at the ready cycle.
- **DIVU:** 100 / 7 → LO = 14, HI = 2.
  - An MFLO presented on the next cycle stalls until IDLE, then `rd_data_o` = 14.
- **DIV:** −100 / 7 → LO = 0xFFFFFFF2 (−14), HI = 0xFFFFFFFE (−2).
  - `md_signed_o` = 1 and `md_sel_mul_o` = 0 held all 35 cycles.
- **Flush mid-operation:** `flush_i` at cycle 10 of a MULTU 5×6.
  - state ABORT, start held to ready, HI/LO keep their prior values (MTHI 0xA5A5A5A5 beforehand).
  - a following MULT stalls until IDLE.
- **Back-to-back:** MULTU 2×3 then MULTU 4×5.
  - the second issues after a 1-cycle start-low gap.
  - final LO = 20, HI = 0.
  - the first result (LO = 6) is committed one cycle earlier.
- **Reset and watchdog:**
  - `rst` during BUSY → all outputs return to reset values next cycle.
  - with `md_ready_i` tied 0, `md_err_o` sets after 40 busy cycles.
